// File: rtl/led_sweep_pkg.sv
// rtl/led_sweep_pkg.sv - register map, mode encodings and state type for the LED sweeper
package led_sweep_pkg;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_DIV    = 2'd1;
   localparam logic [1:0] ADDR_LOOPS  = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   localparam logic [1:0] MODE_STOP    = 2'd0;
   localparam logic [1:0] MODE_ONESHOT = 2'd1;
   localparam logic [1:0] MODE_LOOP    = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_UP   = 2'd1,
      S_DOWN = 2'd2
   } state_t;

   localparam int STAT_BUSY     = 0;
   localparam int STAT_DIR      = 1;
   localparam int STAT_DONE     = 2;
   localparam int STAT_POS_LSB  = 3;
   localparam int STAT_PASS_LSB = 8;

   // Encoding 3 is deliberately not a run mode: it behaves as STOP.
   function automatic logic is_run_mode(input logic [1:0] m);
      return (m == MODE_ONESHOT) || (m == MODE_LOOP);
   endfunction

endpackage

// File: rtl/led_tick_div.sv
// rtl/led_tick_div.sv - reloadable 16-bit down-counter producing one tick per reload period
module led_tick_div (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        load,
   input  logic [15:0] reload,
   output logic        tick
);

   logic [15:0] count;

   assign tick = en && (count == 16'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= 16'd0;
      end else if (load || tick) begin
         count <= reload;
      end else if (en) begin
         count <= count - 16'd1;
      end
   end

endmodule

// File: rtl/led_sweep_wb.sv
// rtl/led_sweep_wb.sv - Wishbone-pipelined slave sweeping a one-hot LED up and back down
module led_sweep_wb #(
   parameter int NLEDS   = 8,
   parameter int DEF_DIV = 2,
   parameter int PW      = $clog2(NLEDS)
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_cyc,
   input  logic             i_stb,
   input  logic             i_we,
   input  logic [1:0]       i_addr,
   input  logic [15:0]      i_data,
   output logic             o_stall,
   output logic             o_ack,
   output logic [15:0]      o_data,
   output logic [NLEDS-1:0] o_led
);
   import led_sweep_pkg::*;

   localparam logic [PW-1:0] POS_TOP = PW'(NLEDS - 1);

   state_t      state, state_nxt;
   logic [PW-1:0] pos, pos_nxt;
   logic [7:0]  pass_cnt, pass_nxt, pass_inc;
   logic        done, done_nxt;
   logic [1:0]  mode;
   logic [15:0] div;
   logic [7:0]  loops;
   logic        tick, busy, accept, ctrl_wr, start;
   logic [4:0]  pos5;
   logic [15:0] status, rd_data;
   logic        unused;

   // Bus cycle framing carries no information for a single-beat slave.
   assign unused = i_cyc;

   assign busy    = (state != S_IDLE);
   assign o_stall = i_we && (i_addr == ADDR_CTRL) && is_run_mode(i_data[1:0]) && busy;
   assign accept  = i_stb && !o_stall;
   assign ctrl_wr = accept && i_we && (i_addr == ADDR_CTRL);
   assign start   = ctrl_wr && is_run_mode(i_data[1:0]);
   assign o_led   = busy ? (NLEDS'(1) << pos) : '0;

   led_tick_div u_tick_div (
      .clk    (i_clk),
      .rst    (i_reset),
      .en     (busy),
      .load   (start),
      .reload (div),
      .tick   (tick)
   );

   always_comb begin
      state_nxt = state;
      pos_nxt   = pos;
      pass_nxt  = pass_cnt;
      done_nxt  = done;
      pass_inc  = (pass_cnt == 8'hff) ? pass_cnt : pass_cnt + 8'd1;
      // A CTRL write always wins over a coincident tick.
      if (ctrl_wr) begin
         pass_nxt  = 8'd0;
         done_nxt  = 1'b0;
         pos_nxt   = '0;
         state_nxt = start ? S_UP : S_IDLE;
      end else if (tick) begin
         unique case (state)
            S_UP: begin
               if (pos == POS_TOP) begin
                  state_nxt = S_DOWN;
                  pos_nxt   = pos - 1'b1;
               end else begin
                  pos_nxt = pos + 1'b1;
               end
            end
            S_DOWN: begin
               if (pos != '0) begin
                  pos_nxt = pos - 1'b1;
               end else begin
                  pass_nxt = pass_inc;
                  if ((mode == MODE_ONESHOT) ||
                      ((loops != 8'd0) && (({1'b0, pass_cnt} + 9'd1) >= {1'b0, loops}))) begin
                     state_nxt = S_IDLE;
                     done_nxt  = 1'b1;
                  end else begin
                     state_nxt = S_UP;
                     pos_nxt   = PW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      pos5 = '0;
      pos5[PW-1:0] = pos;
      status = '0;
      status[STAT_BUSY] = busy;
      status[STAT_DIR]  = (state == S_DOWN);
      status[STAT_DONE] = done;
      status[STAT_POS_LSB +: 5]  = pos5;
      status[STAT_PASS_LSB +: 8] = pass_cnt;
      case (i_addr)
         ADDR_CTRL:  rd_data = {14'd0, mode};
         ADDR_DIV:   rd_data = div;
         ADDR_LOOPS: rd_data = {8'd0, loops};
         default:    rd_data = status;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state    <= S_IDLE;
         pos      <= '0;
         pass_cnt <= 8'd0;
         done     <= 1'b0;
         mode     <= MODE_STOP;
         div      <= 16'(DEF_DIV);
         loops    <= 8'd0;
         o_ack    <= 1'b0;
         o_data   <= 16'd0;
      end else begin
         state    <= state_nxt;
         pos      <= pos_nxt;
         pass_cnt <= pass_nxt;
         done     <= done_nxt;
         o_ack    <= accept;
         if (accept) begin
            o_data <= rd_data;
         end
         if (accept && i_we) begin
            case (i_addr)
               ADDR_CTRL:  mode  <= i_data[1:0];
               ADDR_DIV:   div   <= i_data;
               ADDR_LOOPS: loops <= i_data[7:0];
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_led_sweep_wb.sv
// tb/tb_led_sweep_wb.sv - self-checking bench for led_sweep_wb against a sweep-list model
module tb_led_sweep_wb;
   localparam int NL = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cyc = 1'b0;
   logic          stb = 1'b0;
   logic          we = 1'b0;
   logic [1:0]    addr = 2'd0;
   logic [15:0]   wdata = 16'd0;
   logic          stall;
   logic          ack;
   logic [15:0]   rdata;
   logic [NL-1:0] led;

   int checks = 0;
   int errors = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   led_sweep_wb #(.NLEDS(NL), .DEF_DIV(2)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .i_cyc   (cyc),
      .i_stb   (stb),
      .i_we    (we),
      .i_addr  (addr),
      .i_data  (wdata),
      .o_stall (stall),
      .o_ack   (ack),
      .o_data  (rdata),
      .o_led   (led)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Expected LED value per cycle: pass 1 visits 0..NL-1..0, later passes 1..NL-1..0.
   // Positions with sweep index >= chg_idx are held div_b+1 cycles instead of div_a+1.
   function automatic void model_sweep(input int passes, input int div_a, input int chg_idx, input int div_b);
      int k = 0;
      exp_q.delete();
      for (int p = 0; p < passes; p++) begin
         for (int s = (p == 0) ? 0 : 1; s < 2 * NL - 1; s++) begin
            int p_led = (s < NL) ? s : 2 * NL - 2 - s;
            int hold = (k < chg_idx) ? div_a + 1 : div_b + 1;
            for (int h = 0; h < hold; h++) exp_q.push_back(1 << p_led);
            k++;
         end
      end
      exp_q.push_back(0);
   endfunction

   // Called at a falling edge; returns at the falling edge after acceptance.
   task automatic wb_write(input logic [1:0] a, input logic [15:0] d, output logic got_ack);
      int n = 0;
      cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = a; wdata = d;
      #1;
      while (stall && n < 1000) begin
         @(negedge clk); #1; n++;
      end
      @(posedge clk);
      @(negedge clk);
      got_ack = ack;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic wb_read(input logic [1:0] a, output logic got_ack, output logic [15:0] d);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = a;
      @(posedge clk);
      @(negedge clk);
      got_ack = ack;
      d = rdata;
      cyc = 1'b0; stb = 1'b0;
   endtask

   task automatic test_reset();
      logic a;
      logic [15:0] d;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      wb_write(2'd0, 16'h0002, a);
      #1 rst = 1'b1;
      #1;
      checks++;
      if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", ack); end
      checks++;
      if (led !== '0) begin errors++; $display("FAIL reset_led: got %h want 00", led); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      wb_read(2'd1, a, d);
      checks++;
      if (a !== 1'b1 || d !== 16'h0002) begin errors++; $display("FAIL reset_div: got ack=%b data=%h want ack=1 data=0002", a, d); end
      wb_read(2'd2, a, d);
      checks++;
      if (a !== 1'b1 || d !== 16'h0000) begin errors++; $display("FAIL reset_loops: got ack=%b data=%h want ack=1 data=0000", a, d); end
      wb_read(2'd3, a, d);
      checks++;
      if (a !== 1'b1 || d !== 16'h0000) begin errors++; $display("FAIL reset_status: got ack=%b data=%h want ack=1 data=0000", a, d); end
      wb_write(2'd3, 16'hffff, a);
      wb_read(2'd3, a, d);
      checks++;
      if (a !== 1'b1 || d !== 16'h0000) begin errors++; $display("FAIL status_ro: got ack=%b data=%h want ack=1 data=0000", a, d); end
   endtask

   task automatic test_oneshot();
      logic a;
      logic [15:0] d;
      wb_write(2'd1, 16'h0000, a);
      wb_write(2'd0, 16'h0001, a);
      checks++;
      if (a !== 1'b1) begin errors++; $display("FAIL oneshot_ack: got %b want 1", a); end
      model_sweep(1, 0, 1000, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (led !== NL'(exp_q[i])) begin errors++; $display("FAIL oneshot_led[%0d]: got %h want %h", i, led, NL'(exp_q[i])); end
         @(negedge clk);
      end
      wb_read(2'd3, a, d);
      checks++;
      if (d !== 16'h0104) begin errors++; $display("FAIL oneshot_status: got %h want 0104", d); end
      wb_read(2'd0, a, d);
      checks++;
      if (d !== 16'h0001) begin errors++; $display("FAIL oneshot_ctrl: got %h want 0001", d); end
      wb_write(2'd0, 16'h0003, a);
      wb_read(2'd3, a, d);
      checks++;
      if (d !== 16'h0000) begin errors++; $display("FAIL idle_stop_status: got %h want 0000", d); end
      wb_read(2'd0, a, d);
      checks++;
      if (d !== 16'h0003) begin errors++; $display("FAIL idle_stop_ctrl: got %h want 0003", d); end
   endtask

   task automatic test_stall();
      logic a;
      logic ack_seen = 1'b0;
      int n = 0;
      wb_write(2'd0, 16'h0001, a);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 2'd0; wdata = 16'h0001;
      #1;
      while (stall && n < 200) begin
         if (n > 0 && ack) ack_seen = 1'b1;
         n++;
         @(negedge clk); #1;
      end
      checks++;
      if (n != 2 * NL - 1) begin errors++; $display("FAIL stall_cycles: got %0d want %0d", n, 2 * NL - 1); end
      checks++;
      if (ack_seen !== 1'b0) begin errors++; $display("FAIL stall_no_ack: got ack during stall, want none"); end
      checks++;
      if (led !== '0 || ack !== 1'b0) begin errors++; $display("FAIL stall_idle: got led=%h ack=%b want led=00 ack=0", led, ack); end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (ack !== 1'b1 || led !== NL'(1)) begin errors++; $display("FAIL stall_restart: got ack=%b led=%h want ack=1 led=01", ack, led); end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      repeat (2 * NL) @(negedge clk);
   endtask

   task automatic test_loop();
      logic a;
      logic [15:0] d;
      wb_write(2'd1, 16'd1, a);
      wb_write(2'd2, 16'd2, a);
      wb_write(2'd0, 16'h0002, a);
      model_sweep(2, 1, 1000, 1);
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (led !== NL'(exp_q[i])) begin errors++; $display("FAIL loop_led[%0d]: got %h want %h", i, led, NL'(exp_q[i])); end
         @(negedge clk);
      end
      wb_read(2'd3, a, d);
      checks++;
      if (d !== 16'h0204) begin errors++; $display("FAIL loop_status: got %h want 0204", d); end
   endtask

   task automatic test_stop();
      logic a;
      logic [15:0] d;
      for (int coinc = 0; coinc < 2; coinc++) begin
         int dv = $urandom_range(1, 4);
         int k = 5 * (dv + 1) + ((coinc != 0) ? dv : 0);
         wb_write(2'd1, 16'(dv), a);
         wb_write(2'd0, 16'($urandom_range(1, 2)), a);
         repeat (k) @(negedge clk);
         checks++;
         if (led !== NL'(1 << 5)) begin errors++; $display("FAIL stop_pre[%0d]: got %h want %h", coinc, led, NL'(1 << 5)); end
         cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 2'd0; wdata = 16'h0000;
         #1;
         checks++;
         if (stall !== 1'b0) begin errors++; $display("FAIL stop_stall[%0d]: got %b want 0", coinc, stall); end
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (ack !== 1'b1 || led !== '0) begin errors++; $display("FAIL stop_led[%0d]: got ack=%b led=%h want ack=1 led=00", coinc, ack, led); end
         cyc = 1'b0; stb = 1'b0; we = 1'b0;
         repeat (dv + 2) @(negedge clk);
         wb_read(2'd3, a, d);
         checks++;
         if (d !== 16'h0000 || led !== '0) begin errors++; $display("FAIL stop_status[%0d]: got status=%h led=%h want 0000/00", coinc, d, led); end
      end
   endtask

   task automatic test_live_reconfig();
      logic a;
      logic [15:0] d;
      int k = $urandom_range(2, 10);
      int wd = 2 * k;
      int wl = 2 * (k + 1) + 5 * (20 - (k + 1));
      wb_write(2'd1, 16'd1, a);
      wb_write(2'd2, 16'd0, a);
      wb_write(2'd0, 16'h0002, a);
      model_sweep(2, 1, k + 1, 4);
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (led !== NL'(exp_q[i])) begin errors++; $display("FAIL live_led[%0d]: got %h want %h", i, led, NL'(exp_q[i])); end
         if (i == wd) wb_write(2'd1, 16'd4, a);
         else if (i == wl) wb_write(2'd2, 16'd1, a);
         else @(negedge clk);
      end
      wb_read(2'd3, a, d);
      checks++;
      if (d !== 16'h0204) begin errors++; $display("FAIL live_status: got %h want 0204", d); end
   endtask

   task automatic test_random();
      logic a;
      logic [15:0] d;
      for (int r = 0; r < 3; r++) begin
         int dv = $urandom_range(0, 3);
         int md = $urandom_range(1, 2);
         int lp = (md == 2) ? $urandom_range(1, 3) : $urandom_range(0, 3);
         int passes = (md == 1) ? 1 : lp;
         wb_write(2'd1, 16'(dv), a);
         wb_write(2'd2, 16'(lp), a);
         wb_write(2'd0, 16'(md), a);
         model_sweep(passes, dv, 1000, dv);
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (led !== NL'(exp_q[i])) begin errors++; $display("FAIL rand%0d_led[%0d]: got %h want %h", r, i, led, NL'(exp_q[i])); end
            @(negedge clk);
         end
         wb_read(2'd3, a, d);
         checks++;
         if (d !== 16'((passes << 8) | 4)) begin errors++; $display("FAIL rand%0d_status: got %h want %h", r, d, 16'((passes << 8) | 4)); end
      end
   endtask

   initial begin
      test_reset();
      test_oneshot();
      test_stall();
      test_loop();
      test_stop();
      test_live_reconfig();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_sweep_wb.md
Name: led_sweep_wb

Overview:
- Wishbone-pipelined peripheral that drives a one-hot "sweep" across NLEDS LEDs: up to the top LED, then back down to LED 0.
- Parametrised successor of the fixed 8-LED single-shot sweeper.
- Adds programmable step rate, a continuous bounce mode with a pass limit, a stop/abort command, and readable status.
- Sits on the board Wishbone bus next to the other simple slaves; o_led goes directly to board pins.

Parameters:
- NLEDS, 8, number of LEDs; legal range 2..32.
- DEF_DIV, 2, reset value of the DIV register; each LED position is held DIV+1 cycles.
- PW, $clog2(NLEDS), width of the position counter (derived; not to be overridden).

Ports:
- i_clk  in  1  system clock; all logic on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_cyc  in  1  Wishbone cycle; ignored by the slave beyond bus rules.
- i_stb  in  1  Wishbone strobe.
- i_we  in  1  write enable.
- i_addr  in  2  register select: 0 CTRL, 1 DIV, 2 LOOPS, 3 STATUS.
- i_data  in  16  write data.
- o_stall  out  1  request not accepted this cycle.
- o_ack  out  1  one-cycle acknowledge.
- o_data  out  16  registered read data, valid with o_ack.
- o_led  out  NLEDS  LED drive, one-hot or zero.

Behaviour:
- Reset (asynchronous, takes effect without a clock edge):
  - o_ack=0, o_data=0, o_led=0.
  - state=IDLE, pos=0, mode=0, DIV=DEF_DIV, LOOPS=0, pass_cnt=0, done=0, prescaler=0.
- Accept rule: a request is accepted when i_stb && !o_stall. o_ack is high exactly one cycle after every accepted request and never otherwise. o_data is registered on the same edge.
- o_stall is combinational. It is 1 only when all of the following hold: i_we, i_addr==0, i_data[1:0] is 1 or 2, and state!=IDLE. Reads, DIV/LOOPS writes and STOP writes never stall.
- Registers:
  - CTRL (addr 0): [1:0] mode. 0=STOP, 1=ONESHOT, 2=LOOP, 3=treated as STOP. Reads return the last accepted mode, zero-extended.
  - DIV (addr 1): 16-bit step divider. Read/write.
  - LOOPS (addr 2): [7:0] pass limit for LOOP mode; 0 means run forever. Upper bits read 0.
  - STATUS (addr 3, read-only): [0] busy, [1] dir (1=DOWN), [2] done, [7:3] pos (zero-extended), [15:8] pass_cnt. Writes to STATUS are acked and ignored.
- Any accepted CTRL write clears done and pass_cnt.
- Start: an accepted CTRL write of mode 1/2 in IDLE gives, on the next edge, state=UP, pos=0, o_led=1, prescaler=DIV.
- Prescaler:
  - Decrements each cycle while state!=IDLE.
  - At 0 it produces a tick and reloads DIV.
  - A DIV write during a run takes effect at the next reload.
- State machine (UP, DOWN, IDLE). On a tick:
  - UP, pos<NLEDS-1: pos+1.
  - UP, pos==NLEDS-1: go to DOWN, pos-1.
  - DOWN, pos>0: pos-1.
  - DOWN, pos==0: pass_cnt+1 (saturating at 255). Then:
    - If mode==ONESHOT, or (LOOPS!=0 and pass_cnt+1>=LOOPS): go to IDLE, o_led=0, done=1.
    - Otherwise go to UP with pos=1.
- o_led=(1<<pos) in UP/DOWN; 0 in IDLE. busy=(state!=IDLE).
- One ONESHOT sweep shows 2*NLEDS-1 positions, each held DIV+1 cycles. IDLE is reached (2*NLEDS-1)*(DIV+1) cycles after the start edge.
- STOP write while running: next edge gives IDLE and o_led=0. done stays 0, pos resets to 0. STOP beats a coincident tick. STOP in IDLE is a no-op apart from clearing done and pass_cnt.
- A LOOPS write during a run is compared live, so a limit at or below pass_cnt ends the run at the next pass completion.
- Deasserting i_cyc does not abort a run or cancel a pending o_ack.

Decomposition:
- Package led_sweep_pkg holds:
  - register address constants;
  - mode encodings (MODE_STOP/ONESHOT/LOOP);
  - state enum (IDLE/UP/DOWN);
  - STATUS bit positions.
- One sub-module, led_tick_div: 16-bit reloadable down-counter with enable, reload value and a tick output, cleared by the asynchronous reset.

Test Plan:
- Reset defaults: assert i_reset mid-cycle -> o_led=0 and o_ack=0 immediately. Reads then return DIV=2, LOOPS=0, STATUS=0x0000.
- ONESHOT, NLEDS=8, DIV=0: write CTRL=1 -> o_led steps 01,02,04,…,80,40,…,01, one per cycle (15 positions), then 00. STATUS then reads done=1, busy=0, pass_cnt=1.
- Stall: during a run, issue a write CTRL=1 -> o_stall=1 and no o_ack until IDLE. On the first IDLE cycle the write is accepted, o_ack follows one cycle later, and a new sweep starts at o_led=01.
- LOOP, LOOPS=2, DIV=1: write CTRL=2 -> after the first pass, LED 1 follows LED 0 directly. IDLE at 29 ticks = 58 cycles after the start edge; pass_cnt=2, done=1.
- STOP mid-run, at pos=5 UP: write CTRL=0 -> o_stall=0, o_led=0 on the next edge, busy=0, done=0. Repeat with the write coincident with a tick -> same result.
- Live reconfiguration: in LOOP with LOOPS=0, write DIV=4 mid-step -> the current step keeps its old length and later steps last 5 cycles. Then write LOOPS=1 -> the run ends at the next pass completion.
